// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock time-entry path: entry FSM
// states, 24-hour digit limits and the digit position type.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } entry_state_t;

  // Position 0 = ms_hr, 1 = ls_hr, 2 = ms_min, 3 = ls_min
  typedef logic [1:0] digit_pos_t;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR      = 4'd9;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;
  localparam logic [3:0] MAX_LS_MIN     = 4'd9;

endpackage

// File: rtl/entry_digit_check.sv
// Combinational 24-hour validity check for one candidate keypad digit
// at a given HH:MM position. Codes 10-15 fail at every position because
// every limit is at most 9.
module entry_digit_check
  import alarm_pkg::*;
(
  input  digit_pos_t  pos,
  input  logic [3:0]  digit,
  input  logic [3:0]  ms_hr,
  output logic        ok
);

  // Compare the candidate against the limit for its position
  always_comb begin
    ok = 1'b0;
    case (pos)
      2'd0: ok = (digit <= MAX_MS_HR);
      2'd1: ok = (ms_hr == 4'd2) ? (digit <= MAX_LS_HR_AT_2) : (digit <= MAX_LS_HR);
      2'd2: ok = (digit <= MAX_MS_MIN);
      2'd3: ok = (digit <= MAX_LS_MIN);
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: collects HH:MM digits, validates each one
// as it arrives and issues a one-cycle load strobe to the time counter or
// the alarm register. Optional inactivity abort when ENTRY_TIMEOUT_EN is
// defined.
module time_entry_ctrl
  import alarm_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       clear,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       entry_active,
  output logic [2:0] digit_count,
  output logic       key_error
);

  entry_state_t r_state;
  logic [3:0]   r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic [2:0]   r_count;
  logic         r_load_c, r_load_a, r_err;

  digit_pos_t   w_pos;
  logic         w_ok;
  logic         w_cmd;
  logic         w_timeout;
  logic         w_key_accept;

  // In IDLE the count is 0, so the next position is simply the count
  assign w_pos = r_count[1:0];
  assign w_cmd = set_time | set_alarm;

  entry_digit_check u_check (
    .pos   (w_pos),
    .digit (key_digit),
    .ms_hr (r_ms_hr),
    .ok    (w_ok)
  );

  // A key that will actually be written this cycle
  assign w_key_accept = key_valid && !clear && !w_cmd && !w_timeout &&
                        (r_state != ST_FULL) && w_ok;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_SEC - 1);
  logic [3:0] r_idle_cnt;

  // Abort on the tick that would bring the idle count up to TIMEOUT_SEC
  assign w_timeout = (r_state != ST_IDLE) && one_second && (r_idle_cnt == TO_LAST);

  // Seconds since the last accepted key while an entry is open
  always_ff @(posedge clk) begin
    if (reset || clear || w_timeout || w_key_accept || (r_state == ST_IDLE))
      r_idle_cnt <= 4'd0;
    else if (one_second)
      r_idle_cnt <= r_idle_cnt + 4'd1;
  end
`else
  logic w_unused_one_second;
  assign w_unused_one_second = one_second;
  assign w_timeout = 1'b0;
`endif

  // Entry FSM, digit registers and output strobes
  always_ff @(posedge clk) begin
    r_load_c <= 1'b0;
    r_load_a <= 1'b0;
    r_err    <= 1'b0;
    if (reset || clear || w_timeout) begin
      r_state  <= ST_IDLE;
      r_count  <= 3'd0;
      r_ms_hr  <= 4'd0;
      r_ls_hr  <= 4'd0;
      r_ms_min <= 4'd0;
      r_ls_min <= 4'd0;
      r_err    <= !reset && !clear && w_timeout;
    end else if (w_cmd) begin
      // Any key in the same cycle as a command is dropped
      if (set_time && set_alarm) begin
        r_err <= 1'b1;
      end else if (r_state == ST_FULL) begin
        r_load_c <= set_time;
        r_load_a <= set_alarm;
        r_state  <= ST_IDLE;
        r_count  <= 3'd0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (key_valid) begin
      if (w_key_accept) begin
        case (w_pos)
          2'd0: begin
            r_ms_hr  <= key_digit;
            r_ls_hr  <= 4'd0;
            r_ms_min <= 4'd0;
            r_ls_min <= 4'd0;
          end
          2'd1: r_ls_hr  <= key_digit;
          2'd2: r_ms_min <= key_digit;
          default: r_ls_min <= key_digit;
        endcase
        r_count <= r_count + 3'd1;
        r_state <= (r_count == 3'd3) ? ST_FULL : ST_ENTRY;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign new_time_ms_hr  = r_ms_hr;
  assign new_time_ls_hr  = r_ls_hr;
  assign new_time_ms_min = r_ms_min;
  assign new_time_ls_min = r_ls_min;
  assign load_new_c      = r_load_c;
  assign load_new_a      = r_load_a;
  assign key_error       = r_err;
  assign digit_count     = r_count;
  assign entry_active    = (r_state != ST_IDLE);

endmodule
